// File: rtl/mem_xfer_pkg.sv
// Shared definitions for the mem-to-mem transfer engine and its result-side consumers.
package mem_xfer_pkg;

  localparam int MEMB_DATA_W = 8;
  localparam int MEMB_ADDR_W = 2;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } xfer_state_t;

endpackage

// File: rtl/mask_next_idx.sv
// Combinational priority encoder: lowest set mask bit at or above a start index.
module mask_next_idx #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic [DEPTH-1:0]  i_mask,
  input  logic [ADDR_W:0]   i_start,
  output logic [ADDR_W-1:0] o_idx,
  output logic              o_found
);

  localparam int SW = ADDR_W + 1;

  logic [DEPTH-1:0] w_cand;

  // start is one bit wider than an index so "past the top" is representable
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cand
      assign w_cand[gi] = i_mask[gi] && (SW'(gi) >= i_start);
    end
  endgenerate

  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (w_cand[i]) begin
        o_found = 1'b1;
        o_idx   = ADDR_W'(i);
      end
    end
  end

endmodule

// File: rtl/memb_result_reader.sv
// Captures result-memory B writes into a local buffer, then streams the written
// entries in ascending address order over valid/ready when the batch completes.
module memb_result_reader
  import mem_xfer_pkg::*;
#(
  parameter int DATA_W = MEMB_DATA_W,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = MEMB_ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              web,
  input  logic [ADDR_W-1:0] addrb,
  input  logic [DATA_W-1:0] datainb,
  input  logic              batch_done,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              dout_last,
  output logic              busy,
  output logic              overrun
);

  localparam int SW = ADDR_W + 1;
  localparam logic [ADDR_W:0] DEPTH_C = SW'(DEPTH);

  xfer_state_t       r_state;
  xfer_state_t       w_state_next;
  logic [DEPTH-1:0]  r_mask;
  logic [DEPTH-1:0]  w_mask_next;
  logic [DEPTH-1:0]  w_wr_onehot;
  logic [DEPTH-1:0]  w_mask_eff;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_dout;
  logic              r_valid;
  logic              r_last;
  logic              r_busy;
  logic              r_overrun;
  logic [ADDR_W-1:0] r_next_idx;

  logic              w_addr_ok;
  logic              w_wr_en;
  logic              w_xfer;
  logic              w_load;
  logic              w_drop;
  logic              w_ovr_set;
  logic [ADDR_W-1:0] w_first_idx;
  logic              w_first_found;
  logic [ADDR_W-1:0] w_ld_idx;
  logic [ADDR_W-1:0] w_more_idx;
  logic              w_more_found;
  logic [ADDR_W:0]   w_more_start;

  assign w_addr_ok = ({1'b0, addrb} < DEPTH_C);
  assign w_wr_en   = (r_state == FILL) && web && w_addr_ok;
  assign w_xfer    = r_valid && dout_ready;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_onehot
      assign w_wr_onehot[gi] = w_wr_en && (addrb == ADDR_W'(gi));
    end
  endgenerate

  // Coincident write counts toward the batch that batch_done closes
  assign w_mask_eff = r_mask | w_wr_onehot;

  mask_next_idx #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_first (
    .i_mask  (r_mask),
    .i_start ('0),
    .o_idx   (w_first_idx),
    .o_found (w_first_found)
  );

  // Successor of whatever word is being loaded now; its absence marks the last word
  assign w_ld_idx     = r_valid ? r_next_idx : w_first_idx;
  assign w_more_start = {1'b0, w_ld_idx} + SW'(1);

  mask_next_idx #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_more (
    .i_mask  (r_mask),
    .i_start (w_more_start),
    .o_idx   (w_more_idx),
    .o_found (w_more_found)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= FILL;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_mask_next  = r_mask;
    w_load       = 1'b0;
    w_drop       = 1'b0;
    w_ovr_set    = 1'b0;
    case (r_state)
      FILL: begin
        w_mask_next = w_mask_eff;
        if (web && !w_addr_ok) begin
          w_ovr_set = 1'b1;
        end
        if (batch_done && (w_mask_eff != '0)) begin
          w_state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (web || batch_done) begin
          w_ovr_set = 1'b1;
        end
        if (!r_valid) begin
          if (w_first_found) begin
            w_load = 1'b1;
          end else begin
            w_drop       = 1'b1;
            w_mask_next  = '0;
            w_state_next = FILL;
          end
        end else if (w_xfer) begin
          if (r_last) begin
            w_drop       = 1'b1;
            w_mask_next  = '0;
            w_state_next = FILL;
          end else begin
            w_load = 1'b1;
          end
        end
      end
      default: begin
        w_state_next = FILL;
      end
    endcase
  end

  // Buffer contents survive reset; only the mask says what is valid
  always_ff @(posedge clock) begin
    if (w_wr_en) begin
      r_mem[addrb] <= datainb;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_mask     <= '0;
      r_dout     <= '0;
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
      r_busy     <= 1'b0;
      r_overrun  <= 1'b0;
      r_next_idx <= '0;
    end else begin
      r_mask    <= w_mask_next;
      r_busy    <= (w_state_next == DRAIN);
      r_overrun <= r_overrun | w_ovr_set;
      if (w_load) begin
        r_dout     <= r_mem[w_ld_idx];
        r_valid    <= 1'b1;
        r_last     <= !w_more_found;
        r_next_idx <= w_more_idx;
      end else if (w_drop) begin
        r_valid <= 1'b0;
        r_last  <= 1'b0;
      end
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_valid;
  assign dout_last  = r_last;
  assign busy       = r_busy;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_memb_result_reader.sv
// Directed bench for memb_result_reader: a cycle table plus hand sequences for stalls,
// writes during drain and reset mid-drain.
module tb_memb_result_reader;

  logic       clock;
  logic       reset;
  logic       web;
  logic [1:0] addrb;
  logic [7:0] datainb;
  logic       batch_done;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic       dout_last;
  logic       busy;
  logic       overrun;

  int n_vec = 0;
  int n_bad = 0;

  memb_result_reader #(
    .DATA_W (8),
    .DEPTH  (4),
    .ADDR_W (2)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .web        (web),
    .addrb      (addrb),
    .datainb    (datainb),
    .batch_done (batch_done),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_last  (dout_last),
    .busy       (busy),
    .overrun    (overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic       rst;
    logic       we;
    logic [1:0] a;
    logic [7:0] d;
    logic       bd;
    logic       rdy;
    logic       ev;
    logic [7:0] ed;
    logic       el;
    logic       eb;
    logic       eo;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic we, logic [1:0] a, logic [7:0] d,
                              logic bd, logic rdy, logic ev, logic [7:0] ed,
                              logic el, logic eb, logic eo);
    vec_t v;
    v.rst = rst; v.we = we; v.a = a; v.d = d; v.bd = bd; v.rdy = rdy;
    v.ev = ev; v.ed = ed; v.el = el; v.eb = eb; v.eo = eo;
    return v;
  endfunction

  // Drive one cycle of inputs, then let the edge happen and settle
  task automatic step(input logic rst, input logic we, input logic [1:0] a,
                      input logic [7:0] d, input logic bd, input logic rdy);
    reset      = rst;
    web        = we;
    addrb      = a;
    datainb    = d;
    batch_done = bd;
    dout_ready = rdy;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic ev, input logic [7:0] ed,
                       input logic el, input logic eb, input logic eo, input logic cd);
    n_vec++;
    if (dout_valid !== ev || dout_last !== el || busy !== eb || overrun !== eo ||
        (cd && dout !== ed)) begin
      n_bad++;
      $display("FAIL %s: got v=%b d=%h l=%b b=%b o=%b, want v=%b d=%h l=%b b=%b o=%b",
               name, dout_valid, dout, dout_last, busy, overrun, ev, ed, el, eb, eo);
    end else begin
      $display("ok   %s: v=%b d=%h l=%b b=%b o=%b", name, dout_valid, dout, dout_last,
               busy, overrun);
    end
  endtask

  task automatic fill4();
    step(0, 1, 2'd0, 8'h05, 0, 0);
    step(0, 1, 2'd1, 8'hFB, 0, 0);
    step(0, 1, 2'd2, 8'h10, 0, 0);
    step(0, 1, 2'd3, 8'h80, 0, 0);
  endtask

  initial begin
    reset = 1'b1; web = 1'b0; addrb = '0; datainb = '0; batch_done = 1'b0; dout_ready = 1'b0;

    //            rst we a  d      bd rdy  ev ed     el eb eo
    // reset state, then full batch 05,FB,10,80 with ready held high
    tbl.push_back(mk(1, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 8'h05, 0, 0, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 8'hFB, 0, 0, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 1, 2, 8'h10, 0, 0, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 1, 3, 8'h80, 0, 0, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 1, 1, 0, 8'h00, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 1, 1, 8'h05, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 1, 1, 8'hFB, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 1, 1, 8'h10, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 1, 1, 8'h80, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 0));
    // sparse batch: only 1 and 3 written
    tbl.push_back(mk(0, 1, 1, 8'h22, 0, 0, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 1, 3, 8'h33, 0, 0, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 1, 1, 0, 8'h00, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 1, 1, 8'h22, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 1, 1, 8'h33, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 0));
    // empty batch_done after reset is ignored
    tbl.push_back(mk(1, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 1, 1, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 0));
    // write coincident with batch_done is part of the batch
    tbl.push_back(mk(0, 1, 2, 8'h5A, 1, 0, 0, 8'h00, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 1, 1, 8'h5A, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].we, tbl[i].a, tbl[i].d, tbl[i].bd, tbl[i].rdy);
      check($sformatf("tbl[%0d]", i), tbl[i].ev, tbl[i].ed, tbl[i].el, tbl[i].eb,
            tbl[i].eo, tbl[i].ev | tbl[i].rst);
    end

    // Back-pressure: FB held for three stalled cycles
    step(1, 0, 0, 8'h00, 0, 0);
    fill4();
    step(0, 0, 0, 8'h00, 1, 0);
    check("stall_enter", 0, 8'h00, 0, 1, 0, 0);
    step(0, 0, 0, 8'h00, 0, 0);
    check("stall_w0", 1, 8'h05, 0, 1, 0, 1);
    step(0, 0, 0, 8'h00, 0, 1);
    check("stall_w1", 1, 8'hFB, 0, 1, 0, 1);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 8'h00, 0, 0);
      check($sformatf("stall_hold%0d", k), 1, 8'hFB, 0, 1, 0, 1);
    end
    step(0, 0, 0, 8'h00, 0, 1);
    check("stall_w2", 1, 8'h10, 0, 1, 0, 1);
    step(0, 0, 0, 8'h00, 0, 1);
    check("stall_w3", 1, 8'h80, 1, 1, 0, 1);
    step(0, 0, 0, 8'h00, 0, 1);
    check("stall_done", 0, 8'h00, 0, 0, 0, 0);

    // Write during drain: flagged, not captured, stream intact
    step(1, 0, 0, 8'h00, 0, 0);
    fill4();
    step(0, 0, 0, 8'h00, 1, 1);
    step(0, 0, 0, 8'h00, 0, 1);
    check("ovr_w0", 1, 8'h05, 0, 1, 0, 1);
    step(0, 1, 0, 8'hAA, 0, 1);
    check("ovr_w1", 1, 8'hFB, 0, 1, 1, 1);
    step(0, 0, 0, 8'h00, 0, 1);
    check("ovr_w2", 1, 8'h10, 0, 1, 1, 1);
    step(0, 0, 0, 8'h00, 0, 1);
    check("ovr_w3", 1, 8'h80, 1, 1, 1, 1);
    step(0, 0, 0, 8'h00, 0, 1);
    check("ovr_done", 0, 8'h00, 0, 0, 1, 0);
    step(0, 0, 0, 8'h00, 1, 1);
    check("ovr_empty_bd", 0, 8'h00, 0, 0, 1, 0);
    step(0, 0, 0, 8'h00, 0, 1);
    check("ovr_empty_after", 0, 8'h00, 0, 0, 1, 0);

    // Reset mid-drain loses the partial batch
    step(1, 0, 0, 8'h00, 0, 0);
    fill4();
    step(0, 0, 0, 8'h00, 1, 1);
    step(0, 0, 0, 8'h00, 0, 1);
    check("rst_w0", 1, 8'h05, 0, 1, 0, 1);
    step(0, 0, 0, 8'h00, 0, 1);
    check("rst_w1", 1, 8'hFB, 0, 1, 0, 1);
    step(1, 0, 0, 8'h00, 0, 1);
    check("rst_mid", 0, 8'h00, 0, 0, 0, 1);
    step(0, 0, 0, 8'h00, 1, 1);
    check("rst_empty_bd", 0, 8'h00, 0, 0, 0, 0);
    step(0, 0, 0, 8'h00, 0, 1);
    check("rst_empty_after", 0, 8'h00, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
